// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, sample type, bit-reversal helper and read FSM states for fft_reorder
package fft_pkg;

    localparam int WIDTH = 16;
    localparam int N     = 64;
    localparam int LOG2N = 6;

    typedef struct packed {
        logic signed [WIDTH-1:0] re;
        logic signed [WIDTH-1:0] im;
    } cplx_t;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = idx[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// rtl/fft_reorder_ram.sv - simple dual-port RAM, one write port, one synchronous read port
//
// Ports:
//   clock            system clock
//   wr_en/addr/data  write port
//   rd_en/addr       read request; rd_data valid the cycle after rd_en
//   rd_data          registered read data (old contents on a same-address write)
module fft_reorder_ram #(
    parameter int DW = 32,
    parameter int AW = 7
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_reorder.sv
// rtl/fft_reorder.sv - ping-pong bit-reversal reorder buffer behind the 64-point FFT core
//
// Ports:
//   clock, reset           system clock, synchronous active-low reset
//   di_en/di_re/di_im      input samples in bit-reversed order (no backpressure)
//   do_rdy                 downstream ready
//   do_en/do_re/do_im      output samples in natural order
//   do_sop                 first word of each output frame
//   overrun                sticky flag: an input sample was dropped
//
// Build option: FFT_REORDER_FFTSHIFT_EN emits each frame DC-centred (N/2..N-1, 0..N/2-1).
module fft_reorder
    import fft_pkg::*;
#(
    parameter int WIDTH = fft_pkg::WIDTH,
    parameter int N     = fft_pkg::N,
    parameter int LOG2N = fft_pkg::LOG2N
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    di_en,
    input  logic signed [WIDTH-1:0] di_re,
    input  logic signed [WIDTH-1:0] di_im,
    input  logic                    do_rdy,
    output logic                    do_en,
    output logic signed [WIDTH-1:0] do_re,
    output logic signed [WIDTH-1:0] do_im,
    output logic                    do_sop,
    output logic                    overrun
);

    localparam int AW = LOG2N + 1;
    localparam int DW = 2 * WIDTH;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    logic [LOG2N-1:0] wr_cnt, rd_cnt;
    logic             wr_bank, rd_bank;
    logic [1:0]       full, full_next;
    rd_state_t        state;

    logic             rd_issue, rd_last, rd_release, wr_ok;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [DW-1:0]    ram_q;
    logic             ram_vld, ram_sop;

    logic [1:0]       sk_cnt, occ;
    cplx_t            sk_dat0, sk_dat1;
    logic             sk_sop0, sk_sop1;
    logic             pop;

    assign pop = (sk_cnt != 2'd0) && do_rdy;
    // Words already committed: held in the skid plus one possibly in the RAM pipe.
    assign occ = sk_cnt + {1'b0, ram_vld};

    assign rd_last    = (rd_cnt == LAST);
    assign rd_issue   = full[rd_bank] && ((occ < 2'd2) || (occ == 2'd2 && pop));
    assign rd_release = rd_issue && rd_last;
    // A bank freed on this very edge may take the incoming sample.
    assign wr_ok      = di_en && (!full[wr_bank] || (rd_release && (rd_bank == wr_bank)));

    assign wr_addr = {wr_bank, bitrev(wr_cnt)};
`ifdef FFT_REORDER_FFTSHIFT_EN
    assign rd_addr = {rd_bank, rd_cnt ^ LOG2N'(N / 2)};
`else
    assign rd_addr = {rd_bank, rd_cnt};
`endif

    always_comb begin
        full_next = full;
        if (rd_release) begin
            full_next[rd_bank] = 1'b0;
        end
        if (wr_ok && wr_cnt == LAST) begin
            full_next[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            full    <= 2'b00;
            overrun <= 1'b0;
        end else begin
            full <= full_next;
            if (wr_ok) begin
                if (wr_cnt == LAST) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (di_en && !wr_ok) begin
                overrun <= 1'b1;
            end
        end
    end

    // Read FSM. The first word is issued straight from IDLE so a frame
    // follows its predecessor with no bubble.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
            ram_vld <= 1'b0;
            ram_sop <= 1'b0;
        end else begin
            ram_vld <= rd_issue;
            ram_sop <= rd_issue && (rd_cnt == '0);
            if (rd_issue) begin
                if (rd_last) begin
                    rd_cnt  <= '0;
                    rd_bank <= ~rd_bank;
                    state   <= IDLE;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                    state  <= READ;
                end
            end else if (state == IDLE && full[rd_bank]) begin
                state <= READ;
            end
        end
    end

    fft_reorder_ram #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .wr_data ({di_re, di_im}),
        .rd_en   (rd_issue),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // Two-entry output skid; entry 0 drives the outputs and only moves on a transfer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sk_cnt  <= 2'd0;
            sk_dat0 <= '0;
            sk_dat1 <= '0;
            sk_sop0 <= 1'b0;
            sk_sop1 <= 1'b0;
        end else begin
            case ({ram_vld, pop})
                2'b11: begin
                    if (sk_cnt == 2'd1) begin
                        sk_dat0 <= cplx_t'(ram_q);
                        sk_sop0 <= ram_sop;
                    end else begin
                        sk_dat0 <= sk_dat1;
                        sk_sop0 <= sk_sop1;
                        sk_dat1 <= cplx_t'(ram_q);
                        sk_sop1 <= ram_sop;
                    end
                end
                2'b01: begin
                    sk_dat0 <= sk_dat1;
                    sk_sop0 <= sk_sop1;
                    sk_cnt  <= sk_cnt - 2'd1;
                end
                2'b10: begin
                    if (sk_cnt == 2'd0) begin
                        sk_dat0 <= cplx_t'(ram_q);
                        sk_sop0 <= ram_sop;
                    end else begin
                        sk_dat1 <= cplx_t'(ram_q);
                        sk_sop1 <= ram_sop;
                    end
                    sk_cnt <= sk_cnt + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign do_en  = (sk_cnt != 2'd0);
    assign do_sop = sk_sop0 && do_en;
    assign do_re  = sk_dat0.re;
    assign do_im  = sk_dat0.im;

endmodule

// File: tb/tb_fft_reorder.sv
// tb/tb_fft_reorder.sv - self-checking bench for fft_reorder
module tb_fft_reorder;

`ifdef FFT_REORDER_FFTSHIFT_EN
    localparam int SHIFT = 32;
`else
    localparam int SHIFT = 0;
`endif

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               di_en = 1'b0;
    logic signed [15:0] di_re = '0;
    logic signed [15:0] di_im = '0;
    logic               do_rdy = 1'b0;
    logic               do_en, do_sop, overrun;
    logic signed [15:0] do_re, do_im;

    fft_reorder dut (
        .clock   (clock),
        .reset   (reset),
        .di_en   (di_en),
        .di_re   (di_re),
        .di_im   (di_im),
        .do_rdy  (do_rdy),
        .do_en   (do_en),
        .do_re   (do_re),
        .do_im   (do_im),
        .do_sop  (do_sop),
        .overrun (overrun)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int rdy_mode = 1;   // 0: held low, 1: held high, 2: random
    int t_last   = 0;

    logic signed [15:0] q_re[$];
    logic signed [15:0] q_im[$];
    logic               q_sop[$];
    int                 q_cyc[$];
    logic               hold_v = 1'b0;
    logic [33:0]        hold_val = '0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int brev(input int k);
        int r = 0;
        for (int i = 0; i < 6; i++) begin
            if (k[i]) r = r | (1 << (5 - i));
        end
        return r;
    endfunction

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial forever begin
        @(posedge clock);
        #1;
        do_rdy = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
    end

    // Output monitor: records every transfer and checks hold stability under backpressure.
    initial forever begin
        @(negedge clock);
        if (reset) begin
            if (hold_v) check("hold_stable", {do_en, do_sop, do_re, do_im}, hold_val);
            hold_v   = do_en && !do_rdy;
            hold_val = {do_en, do_sop, do_re, do_im};
            if (do_en && do_rdy) begin
                q_re.push_back(do_re);
                q_im.push_back(do_im);
                q_sop.push_back(do_sop);
                q_cyc.push_back(cyc);
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic do_reset();
        di_en = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("rst_do_en", do_en, 0);
        check("rst_do_sop", do_sop, 0);
        check("rst_overrun", overrun, 0);
        check("rst_do_re", do_re, 0);
        check("rst_do_im", do_im, 0);
        reset = 1'b1;
    endtask

    task automatic feed(input int nsamp, input int gap, input bit chk_ovr);
        for (int s = 0; s < nsamp; s++) begin
            int f, k, v;
            f = s / 64;
            k = s % 64;
            v = f * 64 + brev(k);
            di_en = 1'b1;
            di_re = 16'(v);
            di_im = 16'(-v);
            @(posedge clock);
            #1;
            t_last = cyc;
            if (chk_ovr && ((f == 1 && k == 63) || (f == 2 && k == 0)))
                check($sformatf("overrun_f%0d_k%0d", f, k), overrun, (f >= 2) ? 1 : 0);
            di_en = 1'b0;
            repeat (gap) begin
                @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic collect_and_check(input string name, input int base, input int exp_n,
                                     input bit contig, input bit lat, input logic exp_ovr);
        int to = 0;
        int got, bad;
        while (q_re.size() - base < exp_n && to < 3000) begin
            @(posedge clock);
            #1;
            to++;
        end
        repeat (80) begin
            @(posedge clock);
            #1;
        end
        got = q_re.size() - base;
        check({name, "_count"}, got, exp_n);
        for (int i = 0; i < exp_n && i < got; i++) begin
            int j, v;
            j = i % 64;
            v = (i / 64) * 64 + (j ^ SHIFT);
            check($sformatf("%s_re[%0d]", name, i), q_re[base+i], v);
            check($sformatf("%s_im[%0d]", name, i), q_im[base+i], -v);
            check($sformatf("%s_sop[%0d]", name, i), q_sop[base+i], (j == 0) ? 1 : 0);
        end
        if (contig) begin
            bad = 0;
            for (int i = 1; i < got; i++) begin
                if (q_cyc[base+i] - q_cyc[base+i-1] != 1) bad++;
            end
            check({name, "_gaps"}, bad, 0);
        end
        if (lat && got > 0) check({name, "_latency"}, q_cyc[base] - t_last, 2);
        check({name, "_overrun"}, overrun, exp_ovr);
    endtask

    typedef struct {
        string name;
        int    nsamp;
        int    gap;
        int    rdy;
        int    exp_n;
        logic  exp_ovr;
        bit    contig;
        bit    lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int base;
        vecs[0] = '{"single",  64,  0, 1,  64, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{"b2b",     128, 0, 1, 128, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{"gapped",  64,  1, 1,  64, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{"backpr",  64,  0, 2,  64, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{"overrun", 192, 0, 0, 128, 1'b1, 1'b0, 1'b0};

        @(posedge clock);
        #1;
        for (int v = 0; v < 5; v++) begin
            rdy_mode = vecs[v].rdy;
            do_reset();
            base = q_re.size();
            feed(vecs[v].nsamp, vecs[v].gap, vecs[v].rdy == 0);
            if (rdy_mode == 0) rdy_mode = 1;
            collect_and_check(vecs[v].name, base, vecs[v].exp_n,
                              vecs[v].contig, vecs[v].lat, vecs[v].exp_ovr);
        end

        // Reset in the middle of a frame: the partial frame must vanish.
        rdy_mode = 1;
        do_reset();
        feed(20, 0, 1'b0);
        do_reset();
        base = q_re.size();
        feed(64, 0, 1'b0);
        collect_and_check("midreset", base, 64, 1'b1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fft_reorder.md
Name: fft_reorder

Overview:
- Streaming bit-reversal reorder buffer placed directly downstream of the 64-point FFT core.
- Consumes FFT output samples in bit-reversed index order on the di_en/di_re/di_im stream.
- Emits each frame in natural order on do_en/do_re/do_im with downstream backpressure (do_rdy), feeding the column stage of the 2D FFT.
- Ping-pong double buffering, so a continuous input stream is sustained with no gaps.

Parameters:
- WIDTH, 16, bits per real/imag component (signed two's complement).
- N, 64, frame length in complex samples; power of two.
- LOG2N, 6, log2(N); bit-reversal and counter width.

Ports:
- clock  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset (reset==0 at posedge resets the block).
- di_en  in  1  input sample valid; no ready, so every di_en cycle is one sample.
- di_re  in  WIDTH  input real part, signed.
- di_im  in  WIDTH  input imag part, signed.
- do_rdy  in  1  downstream ready.
- do_en  out  1  output sample valid.
- do_re  out  WIDTH  output real part.
- do_im  out  WIDTH  output imag part.
- do_sop  out  1  high with do_en on natural index 0 of each frame.
- overrun  out  1  sticky: an input sample was dropped.

Behaviour:
- Reset (reset==0 at posedge):
  - wr_cnt, rd_cnt, wr_bank, rd_bank, full[1:0], FSM and output skid are cleared.
  - do_en, do_sop, overrun, do_re and do_im are 0 after that edge.
  - A partial frame is discarded. RAM contents are not cleared.
- Write side:
  - On di_en, store {di_re,di_im} at bank wr_bank, address bitrev(wr_cnt) over LOG2N bits. Then wr_cnt++.
  - When wr_cnt==N-1 is written: set full[wr_bank], toggle wr_bank, wr_cnt=0. All three happen on the same edge.
- Overrun:
  - A write to a bank with full set is dropped: no RAM write, wr_cnt unchanged, overrun=1 until reset.
  - If that bank is released on the same edge, the write is accepted. Release wins.
- Read FSM:
  - IDLE: if full[rd_bank], go to READ with rd_cnt=0.
  - READ: issue a RAM read of address rd_cnt whenever the output skid can accept a word.
  - On issuing rd_cnt==N-1: clear full[rd_bank], toggle rd_bank, return to IDLE. IDLE may re-enter READ on the next edge.
- Output path:
  - RAM read has 1-cycle synchronous latency.
  - A 2-entry output skid guarantees no sample is lost or duplicated when do_rdy deasserts.
  - A sample transfers on a posedge with do_en && do_rdy.
  - While do_en && !do_rdy, do_re, do_im and do_sop must hold stable.
- Latency: with do_rdy=1, if the last sample of a frame is sampled at edge T, the first do_en is visible after edge T+2. The N outputs are then on consecutive cycles.
- Throughput: with do_rdy held high, back-to-back frames produce a continuous do_en stream and overrun stays 0.
- Data passes unmodified. No rounding or scaling.

Optional Feature:
- Macro: FFT_REORDER_FFTSHIFT_EN.
- Defined: read address is rd_cnt ^ (N/2), so output order is N/2..N-1 then 0..N/2-1 (DC centred). do_sop still marks the first word out, natural index N/2.
- Undefined: read address is rd_cnt (natural order 0..N-1).

Decomposition:
- Package fft_pkg holds:
  - WIDTH, N and LOG2N constants.
  - A complex-sample struct typedef {re, im}.
  - A bitrev(idx) function.
  - The FSM state enum (IDLE, READ).
- One sub-module, fft_reorder_ram: simple dual-port memory, 2*N x 2*WIDTH, one write port and one synchronous read port. The address MSB is the bank.

Test Plan:
- Single frame, do_rdy=1: input k carries di_re=bitrev(k), di_im=-bitrev(k), k=0..63 → do_re=0..63 ascending and do_im=0,-1..-63. do_sop only on the first output. Exactly 64 consecutive do_en, first visible 2 cycles after the last input.
- Two back-to-back frames (128 continuous di_en cycles, do_rdy=1) → 128 consecutive do_en with no gap, correct order in both frames, overrun=0.
- Gapped input (di_en every other cycle), one frame → identical output sequence to scenario 1, emitted as one contiguous 64-cycle burst.
- Backpressure: toggle do_rdy pseudo-randomly during output → the accepted sequence is exactly 0..63, and outputs are held stable while !do_rdy.
- Overrun: do_rdy=0 while feeding 3 full frames → overrun=1 from the first sample of frame 3. With do_rdy=1, frames 1 and 2 emerge intact.
- Reset mid-frame: reset=0 after 20 inputs, then a full frame → outputs only the new frame 0..63, overrun=0. Repeat scenario 1 with FFT_REORDER_FFTSHIFT_EN defined → do_re=32..63,0..31.
